// File: rtl/alu_issue_pkg.sv
// Shared constants for the ALU issue controller: opcodes, FSM states, instruction field layout.
package alu_issue_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  localparam int unsigned OPC_LSB   = 26;
  localparam int unsigned RS_LSB    = 21;
  localparam int unsigned RT_LSB    = 16;
  localparam int unsigned RD_LSB    = 11;
  localparam int unsigned SHAMT_LSB = 6;
  localparam int unsigned FUNCT_LSB = 0;
  localparam int unsigned IMM_LSB   = 0;

  localparam int unsigned OPC_W   = 6;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned SHAMT_W = 5;
  localparam int unsigned FUNCT_W = 6;
  localparam int unsigned IMM_W   = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_WB     = 2'd3
  } state_t;

  function automatic logic is_imm_alu(input logic [5:0] op);
    return (op == OP_ADDI) || (op == OP_ADDIU) || (op == OP_ANDI) ||
           (op == OP_ORI)  || (op == OP_XORI)  || (op == OP_SLTI);
  endfunction

  function automatic logic is_branch(input logic [5:0] op);
    return (op == OP_BEQ) || (op == OP_BNE);
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_reg_file.sv
// Register file: two asynchronous read ports, one synchronous write port, register 0 reads zero.
module reg_file #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd
);

  logic [DATA_W-1:0] mem [NUM_REGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) mem[i] <= '0;
    end else if (we && (wa != '0)) begin
      mem[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == '0) ? '0 : mem[ra1];
  assign rd2 = (ra2 == '0) ? '0 : mem[ra2];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/write-back controller for the combinational ALU: latch, decode, execute, write back.
module alu_issue_ctrl #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  input  logic [31:0]       instr,
  output logic              instr_ready,
  output logic [5:0]        opcode,
  output logic [DATA_W-1:0] rs_content,
  output logic [DATA_W-1:0] rt_content,
  output logic [4:0]        shamt,
  output logic [5:0]        ALU_control,
  output logic [15:0]       immediate,
  input  logic [DATA_W-1:0] ALU_result,
  input  logic              sig_branch,
  output logic              wb_valid,
  output logic [4:0]        wb_reg,
  output logic [DATA_W-1:0] wb_data,
  output logic              branch_taken,
  output logic              illegal_op
);
  import alu_issue_pkg::*;

  state_t            state, state_nxt;
  logic [31:0]       instr_q;
  logic [DATA_W-1:0] rf_rd1, rf_rd2;
  logic [REG_W-1:0]  dest;
  logic              dest_branch, dest_illegal;
  logic [OPC_W-1:0]  opc_q;

  assign opc_q = instr_q[OPC_LSB +: OPC_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    instr_ready = 1'b0;
    wb_valid    = 1'b0;
    case (state)
      ST_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_nxt = ST_DECODE;
      end
      ST_DECODE: state_nxt = ST_EXEC;
      ST_EXEC:   state_nxt = ST_WB;
      ST_WB: begin
        wb_valid  = 1'b1;
        state_nxt = ST_IDLE;
      end
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   instr_q <= '0;
    else if ((state == ST_IDLE) && instr_valid) instr_q <= instr;
  end

  // Field outputs are loaded only in DECODE so they stay stable through EXEC and WB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opcode      <= '0;
      rs_content  <= '0;
      rt_content  <= '0;
      shamt       <= '0;
      ALU_control <= '0;
      immediate   <= '0;
    end else if (state == ST_DECODE) begin
      opcode      <= opc_q;
      rs_content  <= rf_rd1;
      rt_content  <= rf_rd2;
      shamt       <= instr_q[SHAMT_LSB +: SHAMT_W];
      ALU_control <= instr_q[FUNCT_LSB +: FUNCT_W];
      immediate   <= instr_q[IMM_LSB +: IMM_W];
    end
  end

  always_comb begin
    dest         = '0;
    dest_branch  = 1'b0;
    dest_illegal = 1'b0;
    if (opc_q == OP_RTYPE)   dest = instr_q[RD_LSB +: REG_W];
    else if (is_imm_alu(opc_q)) dest = instr_q[RT_LSB +: REG_W];
    else if (is_branch(opc_q))  dest_branch = 1'b1;
    else                        dest_illegal = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_reg       <= '0;
      wb_data      <= '0;
      branch_taken <= 1'b0;
      illegal_op   <= 1'b0;
    end else if (state == ST_EXEC) begin
      wb_reg       <= dest;
      wb_data      <= ALU_result;
      branch_taken <= dest_branch & sig_branch;
      illegal_op   <= dest_illegal;
    end
  end

  reg_file #(
    .NUM_REGS (NUM_REGS),
    .DATA_W   (DATA_W),
    .ADDR_W   (REG_W)
  ) u_reg_file (
    .clk (clk),
    .rst (rst),
    .ra1 (instr_q[RS_LSB +: REG_W]),
    .ra2 (instr_q[RT_LSB +: REG_W]),
    .rd1 (rf_rd1),
    .rd2 (rf_rd2),
    .we  (state == ST_WB),
    .wa  (wb_reg),
    .wd  (wb_data)
  );

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl with a behavioural MIPS ALU beside it.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic [5:0]  opcode;
  logic [31:0] rs_content, rt_content;
  logic [4:0]  shamt;
  logic [5:0]  ALU_control;
  logic [15:0] immediate;
  logic [31:0] ALU_result;
  logic        sig_branch;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        branch_taken;
  logic        illegal_op;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.NUM_REGS(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .opcode(opcode), .rs_content(rs_content),
    .rt_content(rt_content), .shamt(shamt), .ALU_control(ALU_control),
    .immediate(immediate), .ALU_result(ALU_result), .sig_branch(sig_branch),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
    .branch_taken(branch_taken), .illegal_op(illegal_op)
  );

  // Behavioural ALU: returns {sig_branch, result}.
  function automatic logic [32:0] alu_fn(input logic [5:0] op, input logic [5:0] fn,
                                         input logic [4:0] sh, input logic [15:0] imm,
                                         input logic [31:0] a, input logic [31:0] b);
    logic [31:0] sx, zx, y;
    logic br;
    sx = {{16{imm[15]}}, imm};
    zx = {16'h0, imm};
    y  = '0;
    br = 1'b0;
    case (op)
      6'h00: case (fn)
        6'h20, 6'h21: y = a + b;
        6'h22, 6'h23: y = a - b;
        6'h24: y = a & b;
        6'h25: y = a | b;
        6'h26: y = a ^ b;
        6'h27: y = ~(a | b);
        6'h2a: y = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        6'h00: y = b << sh;
        6'h02: y = b >> sh;
        6'h03: y = $signed(b) >>> sh;
        default: y = '0;
      endcase
      6'h08, 6'h09: y = a + sx;
      6'h0c: y = a & zx;
      6'h0d: y = a | zx;
      6'h0e: y = a ^ zx;
      6'h0a: y = ($signed(a) < $signed(sx)) ? 32'd1 : 32'd0;
      6'h04: begin y = a - b; br = (a == b); end
      6'h05: begin y = a - b; br = (a != b); end
      default: y = '0;
    endcase
    return {br, y};
  endfunction

  assign {sig_branch, ALU_result} = alu_fn(opcode, ALU_control, shamt, immediate, rs_content, rt_content);

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int sh, input logic [5:0] fn);
    return {6'h00, rs[4:0], rt[4:0], rd[4:0], sh[4:0], fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
    return {op, rs[4:0], rt[4:0], imm};
  endfunction

  typedef struct {
    logic [4:0]  wreg;
    logic [31:0] data;
    logic        br;
    logic        ill;
    logic [31:0] rs;
    logic [31:0] rt;
  } outc_t;

  typedef struct {
    logic [31:0] ins;
    outc_t       exp;
  } vec_t;

  // Architectural register model, updated once per completed instruction.
  logic [31:0] model_rf [32];

  task automatic model_reset();
    for (int i = 0; i < 32; i++) model_rf[i] = '0;
  endtask

  task automatic ref_step(input logic [31:0] ins, output outc_t e);
    logic [5:0]  op;
    logic [32:0] r;
    int          rs_i, rt_i, dst;
    op   = ins[31:26];
    rs_i = int'(ins[25:21]);
    rt_i = int'(ins[20:16]);
    e.rs = (rs_i == 0) ? 32'd0 : model_rf[rs_i];
    e.rt = (rt_i == 0) ? 32'd0 : model_rf[rt_i];
    r    = alu_fn(op, ins[5:0], ins[10:6], ins[15:0], e.rs, e.rt);
    e.data = r[31:0];
    e.br   = 1'b0;
    e.ill  = 1'b0;
    dst    = 0;
    case (op)
      6'h00: dst = int'(ins[15:11]);
      6'h08, 6'h09, 6'h0c, 6'h0d, 6'h0e, 6'h0a: dst = rt_i;
      6'h04, 6'h05: e.br = r[32];
      default: e.ill = 1'b1;
    endcase
    e.wreg = dst[4:0];
    if (dst != 0) model_rf[dst] = r[31:0];
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Issue one instruction from a negedge; returns outcome, latency in cycles and pulse width check.
  task automatic issue(input logic [31:0] ins, output outc_t got, output int lat, output logic one_pulse);
    int n;
    n = 0;
    while (!instr_ready && n < 20) begin @(negedge clk); n++; end
    chk("ready_wait", {31'd0, instr_ready}, 32'd1);
    instr = ins;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    instr = $urandom;
    lat = 1;
    while (!wb_valid && lat < 10) begin @(negedge clk); lat++; end
    got.wreg = wb_reg;
    got.data = wb_data;
    got.br   = branch_taken;
    got.ill  = illegal_op;
    got.rs   = rs_content;
    got.rt   = rt_content;
    @(negedge clk);
    one_pulse = !wb_valid;
  endtask

  task automatic compare(input string tag, input outc_t got, input outc_t e, input int lat, input logic one_pulse);
    chk({tag, "_wb_reg"},  {27'd0, got.wreg}, {27'd0, e.wreg});
    chk({tag, "_wb_data"}, got.data, e.data);
    chk({tag, "_branch"},  {31'd0, got.br}, {31'd0, e.br});
    chk({tag, "_illegal"}, {31'd0, got.ill}, {31'd0, e.ill});
    chk({tag, "_rs"},      got.rs, e.rs);
    chk({tag, "_rt"},      got.rt, e.rt);
    chk({tag, "_latency"}, lat, 3);
    chk({tag, "_pulse"},   {31'd0, one_pulse}, 32'd1);
  endtask

  task automatic run_model(input string tag, input logic [31:0] ins);
    outc_t got, e;
    int lat;
    logic p;
    issue(ins, got, lat, p);
    ref_step(ins, e);
    compare(tag, got, e, lat, p);
  endtask

  initial begin
    vec_t        vecs [10];
    outc_t       got, e;
    int          lat, k, low, wbn, extra;
    logic        p;
    logic [31:0] s5 [3];
    outc_t       s5_exp [$];

    vecs[0] = '{enc_i(6'h08, 0, 1, 16'd15),   '{5'd1, 32'd15, 1'b0, 1'b0, 32'd0,  32'd0}};
    vecs[1] = '{enc_i(6'h08, 0, 2, 16'd12),   '{5'd2, 32'd12, 1'b0, 1'b0, 32'd0,  32'd0}};
    vecs[2] = '{enc_r(1, 2, 3, 0, 6'h20),     '{5'd3, 32'd27, 1'b0, 1'b0, 32'd15, 32'd12}};
    vecs[3] = '{enc_i(6'h04, 1, 1, 16'd4),    '{5'd0, 32'd0,  1'b1, 1'b0, 32'd15, 32'd15}};
    vecs[4] = '{enc_i(6'h04, 1, 2, 16'd4),    '{5'd0, 32'd3,  1'b0, 1'b0, 32'd15, 32'd12}};
    vecs[5] = '{enc_i(6'h05, 1, 2, 16'd4),    '{5'd0, 32'd3,  1'b1, 1'b0, 32'd15, 32'd12}};
    vecs[6] = '{enc_i(6'h08, 0, 0, 16'd5),    '{5'd0, 32'd5,  1'b0, 1'b0, 32'd0,  32'd0}};
    vecs[7] = '{enc_r(0, 0, 4, 0, 6'h20),     '{5'd4, 32'd0,  1'b0, 1'b0, 32'd0,  32'd0}};
    vecs[8] = '{enc_r(1, 0, 6, 0, 6'h20),     '{5'd6, 32'd15, 1'b0, 1'b0, 32'd15, 32'd0}};
    vecs[9] = '{enc_r(3, 1, 5, 0, 6'h22),     '{5'd5, 32'd12, 1'b0, 1'b0, 32'd27, 32'd15}};

    rst = 1'b1;
    instr_valid = 1'b0;
    instr = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_wb_data",  wb_data, 32'd0);
    chk("rst_wb_reg",   {27'd0, wb_reg}, 32'd0);
    chk("rst_opcode",   {26'd0, opcode}, 32'd0);
    chk("rst_rs",       rs_content, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", {31'd0, instr_ready}, 32'd1);

    // Directed table with hand-derived expectations.
    for (int i = 0; i < 10; i++) begin
      issue(vecs[i].ins, got, lat, p);
      ref_step(vecs[i].ins, e);
      compare($sformatf("vec%0d", i), got, vecs[i].exp, lat, p);
    end

    // instr_valid held high across three back-to-back instructions.
    s5[0] = enc_i(6'h08, 0, 7, 16'd1);
    s5[1] = enc_i(6'h08, 7, 8, 16'd2);
    s5[2] = enc_r(7, 8, 9, 0, 6'h20);
    instr = s5[0];
    instr_valid = 1'b1;
    k = 0; low = 0; wbn = 0;
    for (int c = 0; c < 60 && wbn < 3; c++) begin
      if (wb_valid) begin
        if (s5_exp.size() > 0) begin
          e = s5_exp.pop_front();
          chk($sformatf("s5_wb_reg%0d", wbn),  {27'd0, wb_reg}, {27'd0, e.wreg});
          chk($sformatf("s5_wb_data%0d", wbn), wb_data, e.data);
        end
        wbn++;
      end
      if (instr_ready) begin
        if (k > 0) chk("s5_ready_gap", low, 3);
        low = 0;
        if (k < 3) begin
          ref_step(s5[k], e);
          s5_exp.push_back(e);
          k++;
        end else begin
          instr_valid = 1'b0;
        end
      end else begin
        if (low == 0 && k < 3) instr = s5[k];
        low++;
      end
      @(negedge clk);
    end
    instr_valid = 1'b0;
    chk("s5_accepts", k, 3);
    chk("s5_wb_count", wbn, 3);
    extra = 0;
    repeat (8) begin @(negedge clk); if (wb_valid) extra++; end
    chk("s5_no_dup", extra, 0);
    run_model("s5_readback", enc_r(9, 8, 10, 0, 6'h20));

    // Reset asserted in the EXEC cycle of ADD $5,$1,$2.
    instr = enc_r(1, 2, 5, 0, 6'h20);
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_opcode",  {26'd0, opcode}, 32'd0);
    chk("mid_rst_rs",      rs_content, 32'd0);
    chk("mid_rst_rt",      rt_content, 32'd0);
    chk("mid_rst_wb_data", wb_data, 32'd0);
    chk("mid_rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_ready", {31'd0, instr_ready}, 32'd1);
    extra = 0;
    repeat (5) begin @(negedge clk); if (wb_valid) extra++; end
    chk("mid_rst_no_wb", extra, 0);
    run_model("post_rst_read", enc_r(5, 1, 6, 0, 6'h20));
    run_model("illegal", {6'h3f, 5'd0, 5'd7, 16'h0007});
    run_model("illegal_nowrite", enc_r(7, 7, 11, 0, 6'h20));

    // Randomized instruction stream against the reference model.
    for (int n = 0; n < 60; n++) begin
      logic [31:0] ins;
      int sel, rs_i, rt_i, rd_i;
      logic [5:0] fn;
      sel  = $urandom_range(0, 9);
      rs_i = $urandom_range(0, 7);
      rt_i = $urandom_range(0, 7);
      rd_i = $urandom_range(0, 7);
      case ($urandom_range(0, 9))
        0: fn = 6'h20; 1: fn = 6'h21; 2: fn = 6'h22; 3: fn = 6'h24; 4: fn = 6'h25;
        5: fn = 6'h26; 6: fn = 6'h2a; 7: fn = 6'h00; 8: fn = 6'h02; default: fn = 6'h03;
      endcase
      case (sel)
        0, 1, 2: ins = enc_r(rs_i, rt_i, rd_i, $urandom_range(0, 31), fn);
        3: ins = enc_i(6'h08, rs_i, rt_i, 16'($urandom));
        4: ins = enc_i(6'h09, rs_i, rt_i, 16'($urandom));
        5: ins = enc_i(6'h0c, rs_i, rt_i, 16'($urandom));
        6: ins = enc_i(6'h0d, rs_i, rt_i, 16'($urandom));
        7: ins = enc_i(($urandom_range(0, 1) == 1) ? 6'h0e : 6'h0a, rs_i, rt_i, 16'($urandom));
        8: ins = enc_i(($urandom_range(0, 1) == 1) ? 6'h04 : 6'h05, rs_i, rt_i, 16'($urandom));
        default: ins = enc_i(($urandom_range(0, 1) == 1) ? 6'h23 : 6'h3f, rs_i, rt_i, 16'($urandom));
      endcase
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_model($sformatf("rnd%0d", n), ins);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
